// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment controller for low-active HEX displays.
// Sequential shift-add-3 binary-to-BCD conversion with blanking/override modes.
module hex_display_ctrl #(
  parameter int DIGITS    = 4,
  parameter int VAL_W     = 14,
  parameter int BLINK_DIV = 25_000_000,
  parameter int LZB       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VAL_W-1:0]      value,
  input  logic                  load,
  input  logic                  error,
  input  logic                  none,
  input  logic                  blink_en,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(VAL_W + 1);
  localparam int KW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0] S_E     = 7'b0000110;
  localparam logic [6:0] S_UNDER = 7'b1110111;
  localparam logic [6:0] S_BLANK = 7'b1111111;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

  localparam logic [31:0] LIMIT = pow10(DIGITS);
  localparam logic [CW-1:0] LAST = CW'(VAL_W - 1);
  localparam logic [KW-1:0] BTOP = KW'(BLINK_DIV - 1);

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = S_BLANK;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  state_t           state;
  logic [VAL_W-1:0] sr;
  logic [BW-1:0]    acc;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    disp;
  logic [CW-1:0]    cnt;
  logic             ovf_pend;
  logic [KW-1:0]    bcnt;
  logic             phase;
  logic [3:0]       nib;
  logic             nz;

  // add-3 correction applied before each shift
  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      disp     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            sr       <= value;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= {{(32-VAL_W){1'b0}}, value} >= LIMIT;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          {acc, sr} <= {adj, sr} << 1;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST)
            state <= COMMIT;
        end
        COMMIT: begin
          disp  <= acc;
          ovf   <= ovf_pend;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == BTOP) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  // walk from the top digit so nz tracks "any nonzero at or above i"
  always_comb begin
    seg = '1;
    nib = '0;
    nz  = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = disp[4*i +: 4];
      nz  = nz | (nib != 4'd0);
      if (blink_en && phase)
        seg[7*i +: 7] = S_BLANK;
      else if (none)
        seg[7*i +: 7] = S_UNDER;
      else if (error || ovf)
        seg[7*i +: 7] = S_E;
      else if ((LZB != 0) && (i != 0) && !nz)
        seg[7*i +: 7] = S_BLANK;
      else
        seg[7*i +: 7] = dec7(nib);
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed scoreboard bench for hex_display_ctrl.
// Two instances share stimulus: LZB=1 and LZB=0.
module tb_hex_display_ctrl;

  logic        clk;
  logic        rst;
  logic [13:0] value;
  logic        load;
  logic        error;
  logic        none;
  logic        blink_en;
  logic        busy1, done1, ovf1;
  logic        busy0, done0, ovf0;
  logic [27:0] seg1, seg0;

  int ncmp  = 0;
  int nfail = 0;
  int cyc;

  typedef struct {
    logic [27:0] s1;
    logic [27:0] s0;
    logic        ov;
  } exp_t;

  exp_t q[$];

  hex_display_ctrl #(
    .DIGITS(4), .VAL_W(14), .BLINK_DIV(4), .LZB(1)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .error(error), .none(none), .blink_en(blink_en),
    .busy(busy1), .done(done1), .ovf(ovf1), .seg(seg1)
  );

  hex_display_ctrl #(
    .DIGITS(4), .VAL_W(14), .BLINK_DIV(4), .LZB(0)
  ) dut0 (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .error(error), .none(none), .blink_en(blink_en),
    .busy(busy0), .done(done0), .ovf(ovf0), .seg(seg0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edges since reset release, for the blink phase
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [6:0] code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] all4(input logic [6:0] p);
    return {p, p, p, p};
  endfunction

  function automatic logic [27:0] model(input int v, input bit lzb);
    logic [27:0] s;
    int p;
    s = '1;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      if (v >= 10000)
        s[7*i +: 7] = 7'b0000110;
      else if (lzb && i > 0 && v < p)
        s[7*i +: 7] = 7'b1111111;
      else
        s[7*i +: 7] = code((v / p) % 10);
      p = p * 10;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic conv(input int v);
    exp_t e;
    exp_t g;
    int   n;
    bit   got;
    e.s1 = model(v, 1'b1);
    e.s0 = model(v, 1'b0);
    e.ov = (v >= 10000);
    q.push_back(e);
    value = 14'(v);
    load  = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done1) got = 1'b1;
      else chk("busy", 32'({busy1, busy0}), 32'b11);
    end
    chk("latency", 32'(n), 32'd15);
    chk("done", 32'({done1, done0}), 32'b11);
    chk("busy_at_done", 32'({busy1, busy0}), 32'b00);
    if (q.size() > 0) begin
      g = q.pop_front();
      chk("seg_lzb1", 32'(seg1), 32'(g.s1));
      chk("seg_lzb0", 32'(seg0), 32'(g.s0));
      chk("ovf", 32'({ovf1, ovf0}), 32'({g.ov, g.ov}));
    end else begin
      chk("scoreboard_empty", 32'(q.size()), 32'd1);
    end
    @(posedge clk); #1;
    chk("done_pulse", 32'({done1, done0}), 32'b00);
  endtask

  initial begin
    int nd;
    rst      = 1'b1;
    value    = '0;
    load     = 1'b0;
    error    = 1'b0;
    none     = 1'b0;
    blink_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_seg1", 32'(seg1), 32'(model(0, 1'b1)));
    chk("rst_seg0", 32'(seg0), 32'(model(0, 1'b0)));
    chk("rst_flags", 32'({busy1, done1, ovf1}), 32'b000);

    conv(1234);
    chk("disp_1234", 32'(seg1), 32'({code(1), code(2), code(3), code(4)}));
    conv(7);
    chk("disp_7", 32'(seg1), 32'({7'h7f, 7'h7f, 7'h7f, 7'b1111000}));
    conv(10000);
    chk("ovf_all_e", 32'(seg1), 32'(all4(7'b0000110)));
    conv(42);
    conv(1234);

    none  = 1'b1;
    error = 1'b1;
    #1;
    chk("none_pri1", 32'(seg1), 32'(all4(7'b1110111)));
    chk("none_pri0", 32'(seg0), 32'(all4(7'b1110111)));
    none = 1'b0;
    #1;
    chk("error", 32'(seg1), 32'(all4(7'b0000110)));
    error = 1'b0;
    #1;
    chk("restore", 32'(seg1), 32'(model(1234, 1'b1)));

    @(posedge clk); #1;
    blink_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      chk("blink", 32'(seg1),
          ((cyc / 4) % 2) ? 32'h0fffffff : 32'(model(1234, 1'b1)));
    end
    blink_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("steady", 32'(seg1), 32'(model(1234, 1'b1)));
    end

    // abort a conversion with reset; second load must be ignored
    nd    = 0;
    value = 14'd5;
    load  = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done1) nd++;
    end
    value = 14'd99;
    load  = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    chk("busy_ignore", 32'(busy1), 32'd1);
    repeat (4) begin
      @(posedge clk); #1;
      if (done1) nd++;
    end
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'({busy1, busy0}), 32'b00);
    chk("abort_seg1", 32'(seg1), 32'(model(0, 1'b1)));
    chk("abort_seg0", 32'(seg0), 32'(model(0, 1'b0)));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done1 || done0) nd++;
    end
    chk("no_done", 32'(nd), 32'd0);
    chk("post_abort", 32'(seg1), 32'(model(0, 1'b1)));
    chk("post_busy", 32'(busy1), 32'd0);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
